// File: rtl/mem_arbiter.sv
// mem_arbiter
// Two-port round-robin arbiter in front of a single-ported memory controller.
// One transaction is in flight at a time. The winner's request is latched
// in IDLE, presented to the memory for one ACCESS cycle, optionally waits
// RD_LAT cycles for read data, and is acknowledged with a one-cycle pulse
// in RESP.
//
// Parameters:
//   AW      address width
//   DW      data width
//   RD_LAT  cycles from the mem_read strobe until mem_value is valid (>= 1)
//
// Ports:
//   clk, rst_n          clock (rising edge), asynchronous active-low reset
//   req0/1, we0/1       access request and write enable, per port
//   addr0/1, wdata0/1   word address and write data, per port
//   ack0/1              one-cycle completion pulse, per port
//   rdata0/1            read data, valid with ack, held until the next read
//   mem_address/mem_val address and write data towards the controller
//   mem_read/mem_write  one-cycle strobes towards the controller
//   mem_value           read data from the controller
//   busy                high whenever a transaction is in progress
module mem_arbiter #(
    parameter int AW     = 10,
    parameter int DW     = 32,
    parameter int RD_LAT = 1
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          req0,
    input  logic          req1,
    input  logic          we0,
    input  logic          we1,
    input  logic [AW-1:0] addr0,
    input  logic [AW-1:0] addr1,
    input  logic [DW-1:0] wdata0,
    input  logic [DW-1:0] wdata1,
    output logic          ack0,
    output logic          ack1,
    output logic [DW-1:0] rdata0,
    output logic [DW-1:0] rdata1,
    output logic [AW-1:0] mem_address,
    output logic [DW-1:0] mem_val,
    output logic          mem_read,
    output logic          mem_write,
    input  logic [DW-1:0] mem_value,
    output logic          busy
);

    // Counter only needs to hold RD_LAT-1 (the number of extra WAIT cycles).
    localparam int CW = (RD_LAT > 1) ? $clog2(RD_LAT) : 1;

    typedef enum logic [1:0] {
        IDLE,
        ACCESS,
        WAIT,
        RESP
    } state_t;

    state_t          state_q, state_d;
    logic            prio_q, prio_d;
    logic            grant_q, grant_d;
    logic            we_q, we_d;
    logic [AW-1:0]   addr_q, addr_d;
    logic [DW-1:0]   wdata_q, wdata_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [DW-1:0]   rdata0_q, rdata0_d;
    logic [DW-1:0]   rdata1_q, rdata1_d;

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            prio_q   <= 1'b0;
            grant_q  <= 1'b0;
            we_q     <= 1'b0;
            addr_q   <= '0;
            wdata_q  <= '0;
            cnt_q    <= '0;
            rdata0_q <= '0;
            rdata1_q <= '0;
        end else begin
            state_q  <= state_d;
            prio_q   <= prio_d;
            grant_q  <= grant_d;
            we_q     <= we_d;
            addr_q   <= addr_d;
            wdata_q  <= wdata_d;
            cnt_q    <= cnt_d;
            rdata0_q <= rdata0_d;
            rdata1_q <= rdata1_d;
        end
    end

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        state_d  = state_q;
        prio_d   = prio_q;
        grant_d  = grant_q;
        we_d     = we_q;
        addr_d   = addr_q;
        wdata_d  = wdata_q;
        cnt_d    = cnt_q;
        rdata0_d = rdata0_q;
        rdata1_d = rdata1_q;

        unique case (state_q)
            IDLE: begin
                if (req0 || req1) begin
                    // Contention resolves to prio; a lone requester always
                    // wins, which reduces to "grant port 1 iff req1".
                    grant_d = (req0 && req1) ? prio_q : req1;
                    prio_d  = ~grant_d;
                    we_d    = grant_d ? we1    : we0;
                    addr_d  = grant_d ? addr1  : addr0;
                    wdata_d = grant_d ? wdata1 : wdata0;
                    state_d = ACCESS;
                end
            end

            ACCESS: begin
                if (we_q) begin
                    state_d = RESP;
                end else begin
                    cnt_d   = CW'(RD_LAT - 1);
                    state_d = WAIT;
                end
            end

            WAIT: begin
                if (cnt_q == '0) begin
                    if (grant_q) begin
                        rdata1_d = mem_value;
                    end else begin
                        rdata0_d = mem_value;
                    end
                    state_d = RESP;
                end else begin
                    cnt_d = cnt_q - CW'(1);
                end
            end

            RESP: begin
                state_d = IDLE;
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Outputs: decoded from registered state only, so nothing on the
    // request side reaches the memory interface combinationally.
    // ------------------------------------------------------------------
    always_comb begin
        busy        = (state_q != IDLE);
        mem_read    = (state_q == ACCESS) && !we_q;
        mem_write   = (state_q == ACCESS) &&  we_q;
        ack0        = (state_q == RESP)   && !grant_q;
        ack1        = (state_q == RESP)   &&  grant_q;
        mem_address = addr_q;
        mem_val     = wdata_q;
        rdata0      = rdata0_q;
        rdata1      = rdata1_q;
    end

endmodule

// File: tb/tb_mem_arbiter.sv
module tb_mem_arbiter;

    localparam int AW     = 10;
    localparam int DW     = 32;
    localparam int RD_LAT = 3;

    logic          clk;
    logic          rst_n;
    logic          req0, req1, we0, we1;
    logic [AW-1:0] addr0, addr1;
    logic [DW-1:0] wdata0, wdata1;
    logic          ack0, ack1;
    logic [DW-1:0] rdata0, rdata1;
    logic [AW-1:0] mem_address;
    logic [DW-1:0] mem_val;
    logic          mem_read, mem_write;
    logic [DW-1:0] mem_value;
    logic          busy;

    mem_arbiter #(.AW(AW), .DW(DW), .RD_LAT(RD_LAT)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .req0        (req0),
        .req1        (req1),
        .we0         (we0),
        .we1         (we1),
        .addr0       (addr0),
        .addr1       (addr1),
        .wdata0      (wdata0),
        .wdata1      (wdata1),
        .ack0        (ack0),
        .ack1        (ack1),
        .rdata0      (rdata0),
        .rdata1      (rdata1),
        .mem_address (mem_address),
        .mem_val     (mem_val),
        .mem_read    (mem_read),
        .mem_write   (mem_write),
        .mem_value   (mem_value),
        .busy        (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // ---------------- memory controller emulation ----------------
    logic [DW-1:0] env_mem [0:(1<<AW)-1];
    logic [DW-1:0] rd_pipe [0:RD_LAT-1];

    always @(posedge clk) begin
        if (mem_write) env_mem[mem_address] <= mem_val;
        rd_pipe[0] <= mem_read ? env_mem[mem_address] : 32'hBAD0_0BAD;
        for (int i = 1; i < RD_LAT; i++) rd_pipe[i] <= rd_pipe[i-1];
    end
    assign mem_value = rd_pipe[RD_LAT-1];

    // ---------------- reference model + scoreboard ----------------
    typedef struct {
        int            port;
        bit            we;
        int unsigned   addr;
        logic [DW-1:0] wdata;
        logic [DW-1:0] rdata;
        int            cyc;
    } exp_t;

    exp_t          sbq[$];
    logic [DW-1:0] ref_mem [0:(1<<AW)-1];
    bit            prio_m = 1'b0;
    logic [DW-1:0] cur_rd [0:1];
    int unsigned   last_addr = 0;
    logic [DW-1:0] last_val = '0;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    initial begin
        cur_rd[0] = '0;
        cur_rd[1] = '0;
        for (int i = 0; i < (1 << AW); i++) begin
            logic [DW-1:0] v;
            v = $urandom;
            env_mem[i] <= v;
            ref_mem[i] = v;
        end
    end

    // ---------------- monitor ----------------
    exp_t mon_e;
    always @(negedge clk) begin
        if (!rst_n) begin
            sbq.delete();
            cur_rd[0] = '0;
            cur_rd[1] = '0;
            last_addr = 0;
            last_val  = '0;
        end else begin
            if (mem_read || mem_write) begin
                check("strobe_exclusive", 64'(mem_read && mem_write), '0);
                check("strobe_expected", 64'(sbq.size() != 0), 64'(1));
                if (sbq.size() != 0) begin
                    check("strobe_we", 64'(mem_write), 64'(sbq[0].we));
                    check("strobe_addr", 64'(mem_address), 64'(sbq[0].addr));
                    check("strobe_val", 64'(mem_val), 64'(sbq[0].wdata));
                    last_addr = sbq[0].addr;
                    last_val  = sbq[0].wdata;
                end
            end else begin
                check("hold_addr", 64'(mem_address), 64'(last_addr));
                check("hold_val", 64'(mem_val), 64'(last_val));
            end

            if (ack0 || ack1) begin
                check("ack_exclusive", 64'(ack0 && ack1), '0);
                check("ack_expected", 64'(sbq.size() != 0), 64'(1));
                if (sbq.size() != 0) begin
                    mon_e = sbq.pop_front();
                    check("ack_port", 64'(ack1), 64'(mon_e.port));
                    check("ack_cycle", 64'(cyc), 64'(mon_e.cyc));
                    if (!mon_e.we) cur_rd[mon_e.port] = mon_e.rdata;
                    check("rdata0", 64'(rdata0), 64'(cur_rd[0]));
                    check("rdata1", 64'(rdata1), 64'(cur_rd[1]));
                end
            end else if (sbq.size() != 0 && cyc > sbq[0].cyc) begin
                check("ack_timeout", 64'(cyc), 64'(sbq[0].cyc));
                void'(sbq.pop_front());
            end
        end
    end

    // ---------------- driver helpers ----------------
    task automatic wait_cyc(input int target);
        while (cyc < target) @(negedge clk);
    endtask

    task automatic wait_idle();
        for (int g = 0; g < 100 && busy; g++) @(negedge clk);
        check("idle_before_issue", 64'(busy), '0);
    endtask

    task automatic drop(input int port);
        if (port == 0) begin
            req0 = 1'b0; we0 = 1'($urandom); addr0 = AW'($urandom); wdata0 = $urandom;
        end else begin
            req1 = 1'b0; we1 = 1'($urandom); addr1 = AW'($urandom); wdata1 = $urandom;
        end
    endtask

    task automatic issue(input int port, input bit we, input int unsigned addr,
                         input logic [DW-1:0] data, input bit early_drop);
        exp_t e;
        int   t0;
        wait_idle();
        t0 = cyc;
        if (port == 0) begin
            req0 = 1'b1; we0 = we; addr0 = AW'(addr); wdata0 = data;
        end else begin
            req1 = 1'b1; we1 = we; addr1 = AW'(addr); wdata1 = data;
        end
        e.port  = port;
        e.we    = we;
        e.addr  = addr;
        e.wdata = data;
        if (we) ref_mem[addr] = data;
        e.rdata = ref_mem[addr];
        e.cyc   = t0 + (we ? 2 : 2 + RD_LAT);
        prio_m  = (port == 0);
        sbq.push_back(e);
        if (early_drop) begin
            wait_cyc(t0 + 1);
            drop(port);
        end
        wait_cyc(e.cyc);
        drop(port);
        @(negedge clk);
    endtask

    // Both ports request continuously; grants must alternate from prio.
    task automatic both_held(input int k, input int unsigned addr);
        exp_t          e;
        int            t;
        logic [DW-1:0] d0, d1;
        wait_idle();
        d0 = $urandom;
        d1 = $urandom;
        req0 = 1'b1; we0 = 1'b1; addr0 = AW'(addr); wdata0 = d0;
        req1 = 1'b1; we1 = 1'b0; addr1 = AW'(addr); wdata1 = d1;
        t = cyc;
        for (int i = 0; i < k; i++) begin
            e.port  = prio_m ? 1 : 0;
            e.we    = (e.port == 0);
            e.addr  = addr;
            e.wdata = e.we ? d0 : d1;
            if (e.we) ref_mem[addr] = d0;
            e.rdata = ref_mem[addr];
            e.cyc   = t + (e.we ? 2 : 2 + RD_LAT);
            t       = e.cyc + 1;
            prio_m  = ~prio_m;
            sbq.push_back(e);
        end
        wait_cyc(e.cyc);
        drop(0);
        drop(1);
        @(negedge clk);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_ack0"}, 64'(ack0), '0);
        check({tag, "_ack1"}, 64'(ack1), '0);
        check({tag, "_mem_read"}, 64'(mem_read), '0);
        check({tag, "_mem_write"}, 64'(mem_write), '0);
        check({tag, "_busy"}, 64'(busy), '0);
        check({tag, "_rdata0"}, 64'(rdata0), '0);
        check({tag, "_rdata1"}, 64'(rdata1), '0);
        check({tag, "_mem_address"}, 64'(mem_address), '0);
        check({tag, "_mem_val"}, 64'(mem_val), '0);
    endtask

    function automatic int unsigned pick_addr();
        case ($urandom_range(0, 3))
            0:       return 0;
            1:       return 32'h3FF;
            2:       return $urandom_range(1, 4);
            default: return $urandom_range(0, (1 << AW) - 1);
        endcase
    endfunction

    // ---------------- stimulus ----------------
    initial begin
        rst_n = 1'b0;
        req0 = 1'b0; req1 = 1'b0; we0 = 1'b0; we1 = 1'b0;
        addr0 = '0; addr1 = '0; wdata0 = '0; wdata1 = '0;

        // Reset held with random inputs: every output stays 0.
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            req0 = 1'($urandom); req1 = 1'($urandom);
            we0 = 1'($urandom); we1 = 1'($urandom);
            addr0 = AW'($urandom); addr1 = AW'($urandom);
            wdata0 = $urandom; wdata1 = $urandom;
            #1 check_reset_outputs("reset");
        end
        @(negedge clk);
        drop(0);
        drop(1);
        req0 = 1'b0; req1 = 1'b0;
        #1 rst_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check("idle_busy", 64'(busy), '0);
        end

        // Continuous contention straight after reset: 0,1,0,1,...
        both_held(6, 7);

        // Port 0 write then read of address 0.
        issue(0, 1'b1, 0, 32'd42, 1'b0);
        issue(0, 1'b0, 0, $urandom, 1'b0);

        // Port 1 writes top address, port 0 reads it back.
        issue(1, 1'b1, 32'h3FF, 32'hDEADBEEF, 1'b0);
        issue(0, 1'b0, 32'h3FF, $urandom, 1'b0);

        // Request dropped during ACCESS: still acked and written.
        issue(0, 1'b1, 32'h155, 32'hA5A5_1234, 1'b1);
        issue(1, 1'b0, 32'h155, $urandom, 1'b0);

        // Reset pulsed during WAIT of a port 0 read.
        begin
            exp_t e;
            int   t0;
            wait_idle();
            t0 = cyc;
            req0 = 1'b1; we0 = 1'b0; addr0 = '0; wdata0 = $urandom;
            e.port = 0; e.we = 1'b0; e.addr = 0; e.wdata = wdata0;
            e.rdata = ref_mem[0]; e.cyc = t0 + 2 + RD_LAT;
            sbq.push_back(e);
            wait_cyc(t0 + 2);
            check("wait_busy", 64'(busy), 64'(1));
            drop(0);
            #1 rst_n = 1'b0;
            prio_m = 1'b0;
            #1 check_reset_outputs("midreset");
            @(negedge clk);
            check("midreset_no_ack0", 64'(ack0), '0);
            @(negedge clk);
            #1 rst_n = 1'b1;
            @(negedge clk);
            check("post_reset_busy", 64'(busy), '0);
        end
        issue(1, 1'b0, 0, $urandom, 1'b0);

        // Randomized traffic.
        for (int i = 0; i < 40; i++) begin
            int  port;
            bit  we;
            port = $urandom_range(0, 1);
            we   = 1'($urandom);
            issue(port, we, pick_addr(), $urandom, ($urandom_range(0, 3) == 0));
            repeat ($urandom_range(0, 2)) @(negedge clk);
        end

        both_held(5, pick_addr());

        repeat (RD_LAT + 4) @(negedge clk);
        check("scoreboard_empty", 64'(sbq.size()), '0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: time limit reached, checks=%0d failures=%0d", n_checks, n_fail);
        $fatal(1, "watchdog");
    end

endmodule
